// File: rtl/thd_seq_pkg.sv
// Shared definitions for the THD measurement sequencer: state encodings and
// default timing parameters.
`timescale 1ns/1ps
package thd_seq_pkg;

  localparam int DW_DEF          = 16;
  localparam int FFT_RST_CYC_DEF = 256;
  localparam int TMO_W_DEF       = 24;
  localparam int HOLD_CYC_DEF    = 1024;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_FFT_RST = 3'd2,
    ST_FFT_RUN = 3'd3,
    ST_CALC    = 3'd4,
    ST_DONE    = 3'd5,
    ST_FAULT   = 3'd6
  } state_e;

  // States in which a measurement is in flight.
  function automatic logic is_busy(state_e s);
    return (s == ST_CAPTURE) || (s == ST_FFT_RST) || (s == ST_FFT_RUN) || (s == ST_CALC);
  endfunction

  // States supervised by the timeout counter.
  function automatic logic is_timed(state_e s);
    return (s == ST_CAPTURE) || (s == ST_FFT_RUN) || (s == ST_CALC);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for levels arriving from another clock domain.
`timescale 1ns/1ps
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/thd_meas_seq.sv
// THD measurement sequencer: capture -> FFT reset/run -> spectrum write -> THD
// calculation, with per-stage timeouts, result latch and continuous re-arm.
`timescale 1ns/1ps
module thd_meas_seq
  import thd_seq_pkg::*;
#(
  parameter int FFT_RST_CYC = FFT_RST_CYC_DEF,
  parameter int TMO_W       = TMO_W_DEF,
  parameter int HOLD_CYC    = HOLD_CYC_DEF,
  parameter int DW          = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          cont,
  input  logic          cap_done_a,
  input  logic          spec_done_a,
  input  logic          calc_done,
  input  logic [DW-1:0] thd_in,
  output logic          cap_rst_n,
  output logic          fft_aresetn,
  output logic          calc_start,
  output logic          busy,
  output logic [DW-1:0] thd_out,
  output logic          meas_valid,
  output logic          err,
  output logic [2:0]    state
);

  // Phase counter serves both the FFT reset window and the DONE dwell.
  localparam int PH_MAX = (FFT_RST_CYC > HOLD_CYC) ? FFT_RST_CYC : HOLD_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0]  RST_LAST  = PH_W'(FFT_RST_CYC - 1);
  localparam logic [PH_W-1:0]  HOLD_LAST = PH_W'(HOLD_CYC - 1);
  localparam logic [PH_W-1:0]  PH_SAT    = '1;
  localparam logic [TMO_W-1:0] TMO_SAT   = '1;
  // Leaving on the edge where the counter would step to all-ones gives
  // exactly 2^TMO_W - 1 cycles in the supervised state.
  localparam logic [TMO_W-1:0] TMO_LAST  = {{(TMO_W-1){1'b1}}, 1'b0};

  logic [2:0] async_in;
  logic [2:0] sync_out;
  logic       start_s;
  logic       cap_done_s;
  logic       spec_done_s;

  assign async_in = {spec_done_a, cap_done_a, start};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (async_in[gi]),
        .q     (sync_out[gi])
      );
    end
  endgenerate

  assign start_s     = sync_out[0];
  assign cap_done_s  = sync_out[1];
  assign spec_done_s = sync_out[2];

  state_e          state_reg, state_next;
  logic            start_d_reg;
  logic            start_edge_reg;
  logic [PH_W-1:0] ph_reg, ph_next;
  logic [TMO_W-1:0] tmo_reg, tmo_next;
  logic            tmo_hit;

  logic            cap_rst_n_reg, cap_rst_n_next;
  logic            fft_aresetn_reg, fft_aresetn_next;
  logic            calc_start_reg, calc_start_next;
  logic            busy_reg, busy_next;
  logic [DW-1:0]   thd_reg, thd_next;
  logic            meas_valid_reg, meas_valid_next;
  logic            err_reg, err_next;

  assign tmo_hit = (tmo_reg == TMO_LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_edge_reg) state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (cap_done_s)   state_next = ST_FFT_RST;
        else if (tmo_hit) state_next = ST_FAULT;
      end
      ST_FFT_RST: begin
        if (ph_reg == RST_LAST) state_next = ST_FFT_RUN;
      end
      ST_FFT_RUN: begin
        if (spec_done_s)  state_next = ST_CALC;
        else if (tmo_hit) state_next = ST_FAULT;
      end
      ST_CALC: begin
        if (calc_done)    state_next = ST_DONE;
        else if (tmo_hit) state_next = ST_FAULT;
      end
      ST_DONE: begin
        // Re-arming waits for both writers to drop their done levels so a
        // stale done cannot short-circuit the next measurement.
        if (ph_reg >= HOLD_LAST) begin
          if (!cont)                            state_next = ST_IDLE;
          else if (!cap_done_s && !spec_done_s) state_next = ST_CAPTURE;
        end
      end
      ST_FAULT: begin
        if (start_edge_reg) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ph_next  = ph_reg;
    tmo_next = tmo_reg;
    if (state_next != state_reg) begin
      ph_next  = '0;
      tmo_next = '0;
    end else begin
      if (ph_reg != PH_SAT) ph_next = ph_reg + 1'b1;
      if (is_timed(state_reg) && (tmo_reg != TMO_SAT)) tmo_next = tmo_reg + 1'b1;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register.
  always_comb begin
    cap_rst_n_next   = is_busy(state_next);
    busy_next        = is_busy(state_next);
    fft_aresetn_next = (state_next == ST_CAPTURE) || (state_next == ST_FFT_RUN) ||
                       (state_next == ST_CALC);
    calc_start_next  = (state_reg == ST_FFT_RUN) && (state_next == ST_CALC);
    meas_valid_next  = (state_reg == ST_CALC) && (state_next == ST_DONE);
    thd_next         = meas_valid_next ? thd_in : thd_reg;
    err_next         = (state_next == ST_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      start_d_reg     <= 1'b0;
      start_edge_reg  <= 1'b0;
      ph_reg          <= '0;
      tmo_reg         <= '0;
      cap_rst_n_reg   <= 1'b0;
      fft_aresetn_reg <= 1'b0;
      calc_start_reg  <= 1'b0;
      busy_reg        <= 1'b0;
      thd_reg         <= '0;
      meas_valid_reg  <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      start_d_reg     <= start_s;
      start_edge_reg  <= start_s & ~start_d_reg;
      ph_reg          <= ph_next;
      tmo_reg         <= tmo_next;
      cap_rst_n_reg   <= cap_rst_n_next;
      fft_aresetn_reg <= fft_aresetn_next;
      calc_start_reg  <= calc_start_next;
      busy_reg        <= busy_next;
      thd_reg         <= thd_next;
      meas_valid_reg  <= meas_valid_next;
      err_reg         <= err_next;
    end
  end

  assign cap_rst_n   = cap_rst_n_reg;
  assign fft_aresetn = fft_aresetn_reg;
  assign calc_start  = calc_start_reg;
  assign busy        = busy_reg;
  assign thd_out     = thd_reg;
  assign meas_valid  = meas_valid_reg;
  assign err         = err_reg;
  assign state       = state_reg;

endmodule

// File: tb/tb_thd_meas_seq.sv
// Directed-sequence bench for thd_meas_seq with randomized delays and results,
// checked against expected state itineraries, dwell times and a result queue.
`timescale 1ns/1ps
module tb_thd_meas_seq;

  localparam int FFT_RST_CYC = 8;
  localparam int TMO_W       = 8;
  localparam int HOLD_CYC    = 4;
  localparam int DW          = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          cont = 1'b0;
  logic          cap_done_a = 1'b0;
  logic          spec_done_a = 1'b0;
  logic          calc_done = 1'b0;
  logic [DW-1:0] thd_in = '0;
  logic          cap_rst_n;
  logic          fft_aresetn;
  logic          calc_start;
  logic          busy;
  logic [DW-1:0] thd_out;
  logic          meas_valid;
  logic          err;
  logic [2:0]    state;

  always #10 clk = ~clk;

  thd_meas_seq #(
    .FFT_RST_CYC (FFT_RST_CYC),
    .TMO_W       (TMO_W),
    .HOLD_CYC    (HOLD_CYC),
    .DW          (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cont        (cont),
    .cap_done_a  (cap_done_a),
    .spec_done_a (spec_done_a),
    .calc_done   (calc_done),
    .thd_in      (thd_in),
    .cap_rst_n   (cap_rst_n),
    .fft_aresetn (fft_aresetn),
    .calc_start  (calc_start),
    .busy        (busy),
    .thd_out     (thd_out),
    .meas_valid  (meas_valid),
    .err         (err),
    .state       (state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Observation log: state itinerary, pulse widths, FFT reset windows, results.
  int            cyc = 0;
  logic [2:0]    prev_state = 3'd0;
  int            st_q[$];
  int            cs_w[$];
  int            mv_w[$];
  int            fft_w[$];
  logic [DW-1:0] res_q[$];
  int            cs_run = 0;
  int            mv_run = 0;
  int            fft_run = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (state !== prev_state) st_q.push_back(int'(state));
    prev_state <= state;
    if (calc_start) cs_run <= cs_run + 1;
    else if (cs_run != 0) begin
      cs_w.push_back(cs_run);
      cs_run <= 0;
    end
    if (meas_valid) begin
      mv_run <= mv_run + 1;
      res_q.push_back(thd_out);
    end else if (mv_run != 0) begin
      mv_w.push_back(mv_run);
      mv_run <= 0;
    end
    if (!fft_aresetn) fft_run <= fft_run + 1;
    else if (fft_run != 0) begin
      if (state == 3'd3) fft_w.push_back(fft_run);
      fft_run <= 0;
    end
  end

  // Reference model state: expected results and expected state itinerary.
  logic [DW-1:0] exp_res[$];
  int            exp_seq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_for(input string tag, input int target, input int budget, output int n);
    n = 0;
    while ((state !== 3'(target)) && (n < budget)) begin
      step(1);
      n++;
    end
    check(tag, 32'(state), 32'(target));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},       32'(state), 0);
    check({tag, "_cap_rst_n"},   32'(cap_rst_n), 0);
    check({tag, "_fft_aresetn"}, 32'(fft_aresetn), 0);
    check({tag, "_calc_start"},  32'(calc_start), 0);
    check({tag, "_busy"},        32'(busy), 0);
    check({tag, "_thd_out"},     32'(thd_out), 0);
    check({tag, "_meas_valid"},  32'(meas_valid), 0);
    check({tag, "_err"},         32'(err), 0);
  endtask

  task automatic check_seq(input string tag, input int base);
    check({tag, "_len"}, 32'(st_q.size() - base), 32'(exp_seq.size()));
    for (int i = 0; i < exp_seq.size(); i++)
      if (base + i < st_q.size()) check(tag, 32'(st_q[base + i]), 32'(exp_seq[i]));
  endtask

  task automatic start_edge();
    start = 1'b1;
    step(3);
    start = 1'b0;
  endtask

  // Drives one measurement from CAPTURE through to DONE.
  task automatic run_meas(input logic [DW-1:0] val, input bit drop_in_done, input bit poke_start);
    int n;
    step($urandom_range(5, 25));
    cap_done_a = 1'b1;
    wait_for("to_fft_rst", 2, 10, n);
    check("cap_done_latency", 32'(n), 3);
    check("fft_rst_low", 32'(fft_aresetn), 0);
    wait_for("to_fft_run", 3, FFT_RST_CYC + 4, n);
    check("fft_run_high", 32'(fft_aresetn), 1);
    if (poke_start) begin
      start = 1'b1;
      step(3);
      start = 1'b0;
      step(6);
      check("start_ignored_busy", 32'(state), 3);
    end
    step($urandom_range(1, 10));
    spec_done_a = 1'b1;
    wait_for("to_calc", 4, 10, n);
    check("spec_done_latency", 32'(n), 3);
    check("calc_start_hi", 32'(calc_start), 1);
    step($urandom_range(1, 10));
    thd_in    = val;
    calc_done = 1'b1;
    step(1);
    calc_done = 1'b0;
    thd_in    = DW'($urandom);
    exp_res.push_back(val);
    check("to_done", 32'(state), 5);
    check("meas_valid_hi", 32'(meas_valid), 1);
    check("thd_out", 32'(thd_out), 32'(val));
    check("done_busy", 32'(busy), 0);
    if (drop_in_done) begin
      cap_done_a  = 1'b0;
      spec_done_a = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int base;
    int cs_base;
    int mv_base;
    int fft_base;
    int res_cnt;
    logic [DW-1:0] vals[4];

    // Reset values, both while held and after release.
    step(3);
    check_reset_values("in_reset");
    rst_n = 1'b1;
    step(3);
    check_reset_values("after_reset");

    // Single shot.
    cont     = 1'b0;
    base     = st_q.size();
    cs_base  = cs_w.size();
    mv_base  = mv_w.size();
    fft_base = fft_w.size();
    start    = 1'b1;
    wait_for("start_to_capture", 1, 10, n);
    check("start_latency", 32'(n), 4);
    check("capture_cap_rst_n", 32'(cap_rst_n), 1);
    check("capture_busy", 32'(busy), 1);
    start = 1'b0;
    run_meas(16'h0123, 1'b1, 1'b0);
    wait_for("single_to_idle", 0, HOLD_CYC + 6, n);
    check("single_done_dwell", 32'(n), 32'(HOLD_CYC));
    step(4);
    exp_seq = '{1, 2, 3, 4, 5, 0};
    check_seq("single_seq", base);
    check("fft_low_window", (fft_w.size() > fft_base) ? 32'(fft_w[fft_base]) : 32'hffff_ffff, 32'(FFT_RST_CYC));
    check("calc_start_width", (cs_w.size() > cs_base) ? 32'(cs_w[cs_base]) : 32'hffff_ffff, 1);
    check("meas_valid_width", (mv_w.size() > mv_base) ? 32'(mv_w[mv_base]) : 32'hffff_ffff, 1);
    check("single_thd_hold", 32'(thd_out), 32'h0123);

    // Continuous: four measurements, cont drops during the last one.
    vals[0] = 16'h0010;
    vals[1] = 16'h0020;
    vals[2] = DW'($urandom);
    vals[3] = DW'($urandom);
    cont    = 1'b1;
    base    = st_q.size();
    start_edge();
    wait_for("cont_to_capture", 1, 10, n);
    exp_seq = {};
    for (int r = 0; r < 4; r++) begin
      if (r == 3) cont = 1'b0;
      run_meas(vals[r], 1'b1, 1'b0);
      exp_seq.push_back(1);
      exp_seq.push_back(2);
      exp_seq.push_back(3);
      exp_seq.push_back(4);
      exp_seq.push_back(5);
      if (r < 3) begin
        wait_for("cont_recapture", 1, HOLD_CYC + 6, n);
        check("cont_hold_dwell", 32'(n), 32'(HOLD_CYC));
      end
    end
    exp_seq.push_back(0);
    wait_for("cont_to_idle", 0, HOLD_CYC + 6, n);
    step(2);
    check_seq("cont_seq", base);

    // Timeout in CAPTURE, then recovery by start edge.
    start = 1'b1;
    wait_for("tmo_to_capture", 1, 10, n);
    start = 1'b0;
    wait_for("tmo_to_fault", 6, 300, n);
    check("capture_timeout_cycles", 32'(n), 255);
    check("fault_err", 32'(err), 1);
    check("fault_busy", 32'(busy), 0);
    check("fault_cap_rst_n", 32'(cap_rst_n), 0);
    check("fault_fft_aresetn", 32'(fft_aresetn), 0);
    step(10);
    check("fault_err_sticky", 32'(err), 1);
    start = 1'b1;
    wait_for("fault_to_idle", 0, 10, n);
    check("fault_exit_latency", 32'(n), 4);
    check("idle_err_cleared", 32'(err), 0);
    start = 1'b0;
    step(3);

    // Stale capture done held through DONE in continuous mode.
    cont = 1'b1;
    start_edge();
    wait_for("stale_to_capture", 1, 10, n);
    run_meas(DW'($urandom), 1'b0, 1'b0);
    spec_done_a = 1'b0;
    step(20);
    check("stale_hold_done", 32'(state), 5);
    cap_done_a = 1'b0;
    wait_for("stale_release", 1, 10, n);
    check("stale_release_latency", 32'(n), 3);
    cont = 1'b0;
    run_meas(DW'($urandom), 1'b1, 1'b0);
    wait_for("stale_to_idle", 0, HOLD_CYC + 6, n);

    // Start pulse during FFT_RUN is ignored; one measurement completes.
    base = st_q.size();
    start_edge();
    wait_for("busy_to_capture", 1, 10, n);
    run_meas(DW'($urandom_range(1, 65535)), 1'b1, 1'b1);
    wait_for("busy_to_idle", 0, HOLD_CYC + 6, n);
    step(20);
    check("busy_stays_idle", 32'(state), 0);
    exp_seq = '{1, 2, 3, 4, 5, 0};
    check_seq("busy_seq", base);

    // Asynchronous reset in CALC; a later calc_done is ignored.
    start_edge();
    wait_for("rst_to_capture", 1, 10, n);
    cap_done_a = 1'b1;
    wait_for("rst_to_fft_run", 3, FFT_RST_CYC + 10, n);
    spec_done_a = 1'b1;
    wait_for("rst_to_calc", 4, 10, n);
    res_cnt = res_q.size();
    step(2);
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    step(2);
    rst_n       = 1'b1;
    cap_done_a  = 1'b0;
    spec_done_a = 1'b0;
    step(3);
    thd_in    = 16'hbeef;
    calc_done = 1'b1;
    step(1);
    calc_done = 1'b0;
    step(5);
    check("post_reset_state", 32'(state), 0);
    check("post_reset_thd_out", 32'(thd_out), 0);
    check("post_reset_no_result", 32'(res_q.size()), 32'(res_cnt));

    // Every latched result against the model's queue.
    check("result_count", 32'(res_q.size()), 32'(exp_res.size()));
    for (int i = 0; i < exp_res.size(); i++)
      if (i < res_q.size()) check("result_value", 32'(res_q[i]), 32'(exp_res[i]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
